// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_RUN,
    S_ERR
  } loader_state_t;

  localparam int LEN_W     = 16;            // word-count field width
  localparam int LEN_BYTES = LEN_W / 8;     // length prefix bytes
  localparam int LANES     = 4;             // bytes per 32-bit word
  localparam int LANE_W    = $clog2(LANES);
  localparam int PACK_W    = 8 * (LANES - 1);

endpackage

// File: rtl/byte_packer.sv
// Little-endian 8->32 packer: the first byte of each word lands in [7:0],
// the fourth completes the word and is presented combinationally.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [LANE_W-1:0] r_lane;
  logic [PACK_W-1:0] r_pack;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_lane <= '0;
      r_pack <= '0;
    end else if (i_en) begin
      // NOTE: non-blocking so every register samples pre-edge values, matching the hardware.
      r_lane <= r_lane + LANE_W'(1);
      r_pack <= {i_byte, r_pack[PACK_W-1:8]};
    end
  end

  assign word_valid = i_en && (r_lane == LANE_W'(LANES - 1));
  assign word       = {i_byte, r_pack};

endmodule

// File: rtl/imem_loader.sv
// Length-prefixed, XOR-checksummed byte stream loader for the core's IMEM;
// holds the core in reset until a load has been verified.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter  int IMEM_WORDS = 64,
  localparam int AW         = $clog2(IMEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_byte,
  output logic          in_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          core_rst,
  output logic          done,
  output logic          error
);

  loader_state_t    r_state;
  logic [7:0]       r_len_lo;
  logic [LEN_W-1:0] r_last_word;
  logic [AW-1:0]    r_word_cnt;
  logic [7:0]       r_csum;

  logic             w_accept;
  logic             w_word_valid;
  logic [31:0]      w_word;
  logic [LEN_W-1:0] w_len;

  assign in_ready = !rst && (r_state inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK});
  assign w_accept = in_valid && in_ready;
  assign w_len    = {in_byte, r_len_lo};

  // Lane counter restarts on every accepted length so a stale partial word never leaks.
  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_accept && (r_state == S_LEN_HI)),
    .i_en       (w_accept && (r_state == S_DATA)),
    .i_byte     (in_byte),
    .word_valid (w_word_valid),
    .word       (w_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_LEN_LO;
      r_len_lo    <= '0;
      r_last_word <= '0;
      r_word_cnt  <= '0;
      r_csum      <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      core_rst    <= 1'b1;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (r_state)
        S_LEN_LO: if (w_accept) begin
          r_len_lo <= in_byte;
          r_state  <= S_LEN_HI;
        end
        S_LEN_HI: if (w_accept) begin
          if (w_len == '0 || w_len > LEN_W'(IMEM_WORDS)) begin
            r_state <= S_ERR;
            error   <= 1'b1;
          end else begin
            r_last_word <= w_len - LEN_W'(1);
            r_word_cnt  <= '0;
            r_csum      <= '0;
            r_state     <= S_DATA;
          end
        end
        S_DATA: if (w_accept) begin
          r_csum <= r_csum ^ in_byte;
          if (w_word_valid) begin
            imem_we    <= 1'b1;
            imem_addr  <= r_word_cnt;
            imem_wdata <= w_word;
            if (LEN_W'(r_word_cnt) == r_last_word) r_state <= S_CHECK;
            else r_word_cnt <= r_word_cnt + AW'(1);
          end
        end
        S_CHECK: if (w_accept) begin
          if (in_byte == r_csum) begin
            r_state  <= S_RUN;
            core_rst <= 1'b0;
            done     <= 1'b1;
          end else begin
            r_state <= S_ERR;
            error   <= 1'b1;
          end
        end
        default: ;  // S_RUN and S_ERR are left only through rst
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven streams scored against a
// byte-level reference model, plus hand-written reset/stall sequences.
module tb_imem_loader;

  localparam int IMEM_WORDS = 64;
  localparam int AW         = $clog2(IMEM_WORDS);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_byte = 8'h00;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst;
  logic          done;
  logic          error;

  always #5 clk = ~clk;

  imem_loader #(.IMEM_WORDS(IMEM_WORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .done       (done),
    .error      (error)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: one entry per cycle with imem_we high, tagged by cycle number.
  int          cyc = 0;
  int          mon_addr[$];
  logic [31:0] mon_data[$];
  int          mon_cyc[$];
  int          acc_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (imem_we === 1'b1) begin
      mon_addr.push_back(int'(imem_addr));
      mon_data.push_back(imem_wdata);
      mon_cyc.push_back(cyc);
    end
  end

  // Reference model: parse the stream by its rules into expected words and outcome.
  logic [7:0]  stream[$];
  logic [31:0] exp_words[$];
  int          exp_acc;
  bit          exp_ok;

  task automatic model();
    int         n;
    int         b;
    logic [7:0] sum;
    exp_words.delete();
    n = int'(stream[0]) + 256 * int'(stream[1]);
    if (n == 0 || n > IMEM_WORDS) begin
      exp_acc = 2;
      exp_ok  = 1'b0;
      return;
    end
    sum = 8'h00;
    for (int i = 0; i < n; i++) begin
      b = 2 + 4 * i;
      exp_words.push_back(32'(stream[b]) + 32'(stream[b+1]) * 256 +
                          32'(stream[b+2]) * 65536 + 32'(stream[b+3]) * 16777216);
      for (int k = 0; k < 4; k++) sum = sum ^ stream[b+k];
    end
    exp_ok  = (stream[2 + 4 * n] == sum);
    exp_acc = 3 + 4 * n;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    ok = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_byte  = b;
      if (in_ready) begin
        @(posedge clk);
        acc_cyc.push_back(cyc + 1);
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Ends on the negedge right after the last accepting edge.
  task automatic run_stream(input int gap_max, output int n_acc);
    bit ok;
    n_acc = 0;
    foreach (stream[i]) begin
      send_byte(stream[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0, ok);
      if (!ok) break;
      n_acc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"},    in_ready,   0);
    check({tag, "_we"},       imem_we,    0);
    check({tag, "_addr"},     imem_addr,  0);
    check({tag, "_wdata"},    imem_wdata, 0);
    check({tag, "_core_rst"}, core_rst,   1);
    check({tag, "_done"},     done,       0);
    check({tag, "_error"},    error,      0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check_reset(tag);
    rst = 1'b0;
    #1;
    check({tag, "_ready_idle"}, in_ready, 1);
    mon_addr.delete();
    mon_data.delete();
    mon_cyc.delete();
    acc_cyc.delete();
  endtask

  typedef enum int {K_NOM, K_LEN, K_RAMP, K_RAND} kind_e;

  typedef struct {
    string name;
    kind_e kind;
    int    n;
    bit    corrupt;
    int    gap;
    bit    exp_done;
    bit    exp_err;
    int    exp_writes;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] nom[11];

  task automatic add_vec(input string name, input kind_e kind, input int n, input bit corrupt,
                         input int gap, input bit d, input bit e, input int w);
    vec_t v;
    v.name = name;  v.kind = kind;   v.n = n;          v.corrupt = corrupt;
    v.gap = gap;    v.exp_done = d;  v.exp_err = e;    v.exp_writes = w;
    tbl.push_back(v);
  endtask

  task automatic build_stream(input vec_t v);
    logic [7:0] b;
    logic [7:0] sum;
    stream.delete();
    case (v.kind)
      K_NOM: begin
        for (int i = 0; i < 11; i++) stream.push_back(nom[i]);
        if (v.corrupt) stream[10] = 8'h70;
      end
      K_LEN: begin
        stream.push_back(8'(v.n));
        stream.push_back(8'(v.n >> 8));
      end
      default: begin
        stream.push_back(8'(v.n));
        stream.push_back(8'(v.n >> 8));
        sum = 8'h00;
        for (int i = 0; i < v.n; i++)
          for (int k = 0; k < 4; k++) begin
            if (v.kind == K_RAMP) b = (k == 0) ? 8'(i) : 8'h00;
            else b = 8'($urandom);
            stream.push_back(b);
            sum = sum ^ b;
          end
        if (v.corrupt) sum = sum ^ 8'($urandom_range(1, 255));
        stream.push_back(sum);
      end
    endcase
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    int idx;
    int nw;
    bit ok;

    nom = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};

    add_vec("nominal",     K_NOM,  2,   0, 0, 1, 0, 2);
    add_vec("bad_sum",     K_NOM,  2,   1, 0, 0, 1, 2);
    add_vec("len_zero",    K_LEN,  0,   0, 0, 0, 1, 0);
    add_vec("len_65",      K_LEN,  65,  0, 0, 0, 1, 0);
    add_vec("len_256",     K_LEN,  256, 0, 0, 0, 1, 0);
    add_vec("stall_nom",   K_NOM,  2,   0, 3, 1, 0, 2);
    add_vec("full_depth",  K_RAMP, 64,  0, 0, 1, 0, 64);
    add_vec("one_word",    K_RAND, 1,   0, 0, 1, 0, 1);
    add_vec("rand7_gaps",  K_RAND, 7,   0, 2, 1, 0, 7);
    add_vec("rand13_bad",  K_RAND, 13,  1, 1, 0, 1, 13);

    foreach (tbl[v]) begin
      build_stream(tbl[v]);
      model();
      do_reset({tbl[v].name, "_rst"});
      run_stream(tbl[v].gap, n_acc);
      check({tbl[v].name, "_accepted"},  n_acc, exp_acc);
      check({tbl[v].name, "_done_lat"},  done,  tbl[v].exp_done);
      check({tbl[v].name, "_error_lat"}, error, tbl[v].exp_err);

      // Bytes offered after the load is finished must be refused.
      @(negedge clk);
      in_valid = 1'b1;
      in_byte  = 8'($urandom);
      check({tbl[v].name, "_ready_after"}, in_ready, 0);
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);

      check({tbl[v].name, "_writes"}, mon_data.size(), tbl[v].exp_writes);
      nw = (mon_data.size() < exp_words.size()) ? mon_data.size() : exp_words.size();
      for (int i = 0; i < nw; i++) begin
        idx = 5 + 4 * i;
        check($sformatf("%s_addr%0d", tbl[v].name, i), mon_addr[i], i);
        check($sformatf("%s_data%0d", tbl[v].name, i), mon_data[i], exp_words[i]);
        check($sformatf("%s_wlat%0d", tbl[v].name, i), mon_cyc[i],
              (idx < acc_cyc.size()) ? acc_cyc[idx] : -1);
      end
      check({tbl[v].name, "_done"},     done,     tbl[v].exp_done);
      check({tbl[v].name, "_error"},    error,    tbl[v].exp_err);
      check({tbl[v].name, "_core_rst"}, core_rst, !tbl[v].exp_done);
    end

    // Reset mid-load: five bytes in, the partial word must vanish.
    do_reset("mid_pre");
    stream.delete();
    for (int i = 0; i < 11; i++) stream.push_back(nom[i]);
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      send_byte(stream[i], 0, ok);
      if (ok) n_acc++;
    end
    check("mid_accepted", n_acc, 5);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_byte  = 8'h00;
    #1;
    check("mid_ready_in_rst", in_ready, 0);
    @(negedge clk);
    check_reset("mid_rst");
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_no_write", mon_data.size(), 0);

    acc_cyc.delete();
    run_stream(0, n_acc);
    repeat (3) @(negedge clk);
    check("replay_writes", mon_data.size(), 2);
    if (mon_data.size() >= 2) begin
      check("replay_addr0", mon_addr[0], 0);
      check("replay_data0", mon_data[0], 32'h00500093);
      check("replay_addr1", mon_addr[1], 1);
      check("replay_data1", mon_data[1], 32'h00A00113);
    end
    check("replay_done",     done,     1);
    check("replay_core_rst", core_rst, 0);
    check("replay_error",    error,    0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes into the instruction memory the `beaver32rv` core fetches from. It accepts a length-prefixed, checksummed byte stream over a valid/ready handshake and packs the bytes little-endian into 32-bit words. It writes those words to consecutive IMEM addresses while holding the core in reset, and releases the core only after a verified load.

## Interface
- `IMEM_WORDS`, default 64: instruction memory depth in 32-bit words; address width `AW = $clog2(IMEM_WORDS)`.
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: a stream byte is present on `in_byte`.
- `in_byte` in 8: stream byte.
- `in_ready` out 1: loader can accept a byte; transfer occurs when `in_valid && in_ready` at a rising edge.
- `imem_we` out 1: one-cycle write strobe to IMEM.
- `imem_addr` out AW: word address.
- `imem_wdata` out 32: word data.
- `core_rst` out 1: reset to the core; high until a successful load.
- `done` out 1: load verified, core running.
- `error` out 1: load rejected.

## Operation
- Stream format: `LEN_LO`, `LEN_HI` (16-bit word count N, little-endian), then 4N payload bytes, then 1 checksum byte. The checksum is the XOR of all payload bytes; length bytes are excluded.
- States: `S_LEN_LO`, `S_LEN_HI`, `S_DATA`, `S_CHECK`, `S_RUN`, `S_ERR`. Reset enters `S_LEN_LO`.
- `S_LEN_LO`: on accept, latch N[7:0] and go to `S_LEN_HI`.
- `S_LEN_HI`: on accept, latch N[15:8].
  - If N==0 or N>IMEM_WORDS, go to `S_ERR`.
  - Otherwise go to `S_DATA`, with byte counter=0, word counter=0, and checksum accumulator=0.
- `S_DATA`: each accepted byte is XORed into the accumulator and shifted into the pack register. The first byte of a word lands in bits [7:0] and the fourth in [31:24].
  - On the 4th byte, write the word: `imem_we`=1, `imem_addr`=word counter, `imem_wdata`=packed word.
  - The word counter increments after each write.
  - After word N-1 is written, go to `S_CHECK`.
- `S_CHECK`: on accept, compare the byte with the accumulator.
  - Equal: go to `S_RUN`.
  - Not equal: go to `S_ERR`.
- `S_RUN`: `core_rst`=0, `done`=1, `in_ready`=0. Any further stream bytes are ignored. Only `rst` leaves this state.
- `S_ERR`: `error`=1, `core_rst`=1, `in_ready`=0. Only `rst` leaves this state.
- Word counter never exceeds N-1 ≤ IMEM_WORDS-1, so the address never wraps.

## Timing
- Registered outputs: `imem_we`, `imem_addr`, `imem_wdata`, `core_rst`, `done`, `error`.
- `in_ready` is decoded from state: it is 1 in `S_LEN_LO`, `S_LEN_HI`, `S_DATA` and `S_CHECK`, and is forced 0 while `rst`=1.
- Reset values: `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `core_rst`=1, `done`=0, `error`=0, `in_ready`=0.
- Write latency: `imem_we` is high for exactly one cycle, the cycle after the edge that accepted the 4th byte of a word.
- Throughput: one byte per cycle; no bubbles are inserted by the loader.
- The checksum byte may be accepted in the same cycle that the last word's `imem_we` is high.
- `core_rst` falls and `done` rises on the edge after the checksum byte is accepted. The same timing applies to `error` on a bad checksum.
- A length error raises `error` on the edge after `LEN_HI` is accepted.
- `in_valid` may deassert at any time. State, counters and the pack register hold while no transfer occurs.
- `rst` mid-load takes effect on the next edge: all state and counters clear, outputs return to reset values, and a partial word is discarded and never written.

## Structure
- Package `imem_loader_pkg`: state enum typedef `loader_state_t`, and the constants for length and byte-lane counts.
- Sub-module `byte_packer`: 8→32 little-endian shift/pack with a 2-bit lane counter. It outputs `word_valid` and `word`. The FSM, counters, checksum and IMEM port stay in `imem_loader`.

## Test plan
- **Nominal load:** stream `02 00 93 00 50 00 13 01 A0 00 71` with `in_valid` held high.
  - Writes addr 0 = 0x00500093, then addr 1 = 0x00A00113.
  - Then `done`=1 and `core_rst`=0. Optionally run the core: x1=5, x2=10.
- **Bad checksum:** same stream with last byte `70`.
  - Both words are written.
  - Then `error`=1, `core_rst` stays 1, `done`=0, `in_ready`=0.
- **Length errors:**
  - `00 00` → `error`=1 one cycle after `LEN_HI`, no `imem_we`.
  - `41 00` with IMEM_WORDS=64 → same.
- **Stalls:** the nominal stream with random `in_valid` gaps gives identical writes and final state.
  - `imem_we` pulses exactly twice, each one cycle wide.
- **Reset mid-load:** assert `rst` after 5 bytes of the nominal stream.
  - Outputs return to reset values and no write occurs for the partial word.
  - Replaying the full stream then loads addr 0/1 correctly.
- **Full depth:** N=64 (`40 00`) with payload word i = i and the correct checksum.
  - The last write is addr 63 = 0x0000003F, then `done`=1.
  - Extra bytes after `done` see `in_ready`=0.
